// File: rtl/tero_response_collector_if.sv
// Sequencer-to-collector bus plus the response valid/ready channel.
// master = sequencer/downstream side, slave = collector side.
interface tero_response_collector_if #(
  parameter int NUM_LOOPS  = 4,
  parameter int COUNT_BITS = 8,
  parameter int SEL_BITS   = $clog2(NUM_LOOPS-1)+1
);
  logic                   reset_puf;
  logic [SEL_BITS-1:0]    select_puf;
  logic                   enable_puf;
  logic                   store_response_puf;
  logic                   done;
  logic [COUNT_BITS-1:0]  osc_count;
  logic                   next_enable;
  logic [NUM_LOOPS/2-1:0] response;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   overrun;

  modport master (
    output reset_puf, select_puf, enable_puf,
    output store_response_puf, done, osc_count,
    output resp_ready,
    input  next_enable, response, resp_valid, overrun
  );

  modport slave (
    input  reset_puf, select_puf, enable_puf,
    input  store_response_puf, done, osc_count,
    input  resp_ready,
    output next_enable, response, resp_valid, overrun
  );
endinterface

// File: rtl/tero_response_collector.sv
// TERO PUF response collector: accumulates per-loop oscillation counts,
// averages them into a table and compares loop pairs into a response word.
module tero_response_collector #(
  parameter int NUM_LOOPS        = 4,
  parameter int REPETITIONS_BITS = 13,
  parameter int COUNT_BITS       = 8,
  parameter int SEL_BITS         = $clog2(NUM_LOOPS-1)+1
) (
  input  logic clk,
  input  logic reset,
  tero_response_collector_if.slave bus
);
  localparam int ACC_BITS = COUNT_BITS + REPETITIONS_BITS;
  localparam int PAIRS    = NUM_LOOPS / 2;
  localparam int KW       = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int SH       = REPETITIONS_BITS - 1;

  typedef enum logic [1:0] {
    COLLECT,
    COMPARE,
    OUTPUT,
    WAIT_IDLE
  } state_t;

  state_t state_q, state_d;
  logic en_q, done_q;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [REPETITIONS_BITS-1:0] cnt_q, cnt_d;
  logic [COUNT_BITS-1:0] avg_q [NUM_LOOPS];
  logic [COUNT_BITS-1:0] avg_d [NUM_LOOPS];
  logic [KW-1:0] k_q, k_d;
  logic [PAIRS-1:0] resp_q, resp_d;
  logic valid_q, valid_d;
  logic ovr_q, ovr_d;

  logic fall;
  logic [ACC_BITS:0] sum_w;
  logic [ACC_BITS-1:0] sum_sat;

  assign fall = en_q & ~bus.enable_puf;

  // sum_sat folds in a coincident falling-edge sample before saturation
  always_comb begin
    sum_w = {1'b0, acc_q}
          + {{(ACC_BITS+1-COUNT_BITS){1'b0}},
             (fall ? bus.osc_count : '0)};
    sum_sat = sum_w[ACC_BITS] ? '1 : sum_w[ACC_BITS-1:0];
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    k_d     = k_q;
    resp_d  = resp_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      COLLECT: begin
        if (fall) begin
          acc_d = sum_sat;
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.store_response_puf) begin
          for (int i = 0; i < NUM_LOOPS; i++) begin
            if (bus.select_puf == SEL_BITS'(i))
              avg_d[i] = sum_sat[SH +: COUNT_BITS];
          end
          acc_d = '0;
          cnt_d = '0;
        end
        if (bus.reset_puf) begin
          acc_d = '0;
          cnt_d = '0;
        end
        if (bus.done && !done_q) begin
          state_d = COMPARE;
          k_d     = '0;
        end
      end
      COMPARE: begin
        for (int p = 0; p < PAIRS; p++) begin
          if (k_q == KW'(p))
            resp_d[p] = avg_q[2*p] > avg_q[2*p+1];
        end
        if (k_q == KW'(PAIRS-1)) begin
          state_d = OUTPUT;
          valid_d = 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (bus.resp_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!bus.done) begin
          state_d = COLLECT;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (state_q != COLLECT &&
        (fall || bus.store_response_puf))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= COLLECT;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      resp_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_LOOPS; i++)
        avg_q[i] <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= bus.enable_puf;
      done_q  <= bus.done;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      resp_q  <= resp_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      avg_q   <= avg_d;
    end
  end

  assign bus.next_enable = (state_q == COLLECT);
  assign bus.response    = resp_q;
  assign bus.resp_valid  = valid_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_tero_response_collector.sv
// Directed bench for tero_response_collector (4 loops, 4 repetitions).
// Each task drives one scenario and checks its own expected values.
module tb_tero_response_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tero_response_collector_if #(
    .NUM_LOOPS(4), .COUNT_BITS(8)
  ) bus ();

  tero_response_collector #(
    .NUM_LOOPS(4),
    .REPETITIONS_BITS(3),
    .COUNT_BITS(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rep(input logic [7:0] v);
    bus.osc_count = v;
    bus.enable_puf = 1'b1;
    tick();
    bus.enable_puf = 1'b0;
    tick();
  endtask

  task automatic load(input logic [2:0] sel,
                      input logic [7:0] a, b, c, d);
    bus.select_puf = sel;
    bus.reset_puf = 1'b1;
    tick();
    bus.reset_puf = 1'b0;
    rep(a); rep(b); rep(c); rep(d);
    bus.store_response_puf = 1'b1;
    tick();
    bus.store_response_puf = 1'b0;
  endtask

  task automatic test_reset();
    bus.reset_puf = 0; bus.select_puf = 0;
    bus.enable_puf = 0; bus.store_response_puf = 0;
    bus.done = 0; bus.osc_count = 0; bus.resp_ready = 0;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if (bus.next_enable !== 1'b1) begin
      bad++; $display("FAIL rst_next_enable got=%b exp=1", bus.next_enable);
    end
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", bus.resp_valid);
    end
    total++;
    if (bus.response !== 2'b00) begin
      bad++; $display("FAIL rst_response got=%b exp=00", bus.response);
    end
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++; $display("FAIL rst_overrun got=%b exp=0", bus.overrun);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_backpressure();
    load(3'd0, 10, 10, 10, 10);
    load(3'd1, 8, 8, 8, 8);
    load(3'd2, 5, 5, 5, 5);
    load(3'd3, 9, 9, 9, 9);
    bus.done = 1'b1;
    tick();
    total++;
    if (bus.next_enable !== 1'b0 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL lat_c1 got ne=%b v=%b exp ne=0 v=0",
                      bus.next_enable, bus.resp_valid);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL lat_c2 got v=%b exp=0", bus.resp_valid);
    end
    tick();
    total++;
    if (bus.resp_valid !== 1'b1) begin
      bad++; $display("FAIL lat_c3 got v=%b exp=1", bus.resp_valid);
    end
    total++;
    if (bus.response !== 2'b01) begin
      bad++; $display("FAIL basic_resp got=%b exp=01", bus.response);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.resp_valid !== 1'b1 || bus.response !== 2'b01) begin
        bad++; $display("FAIL hold_%0d got v=%b r=%b exp v=1 r=01",
                        i, bus.resp_valid, bus.response);
      end
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.next_enable !== 1'b0) begin
      bad++; $display("FAIL hs_drop got v=%b ne=%b exp v=0 ne=0",
                      bus.resp_valid, bus.next_enable);
    end
    bus.done = 1'b0;
    tick();
    total++;
    if (bus.next_enable !== 1'b1) begin
      bad++; $display("FAIL idle_ret got ne=%b exp=1", bus.next_enable);
    end
  endtask

  task automatic run_and_check(input string nm,
                               input logic [1:0] exp);
    bus.done = 1'b1;
    tick(); tick(); tick();
    total++;
    if (bus.resp_valid !== 1'b1 || bus.response !== exp) begin
      bad++; $display("FAIL %s got v=%b r=%b exp v=1 r=%b",
                      nm, bus.resp_valid, bus.response, exp);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    bus.done = 1'b0;
    tick();
  endtask

  task automatic test_coincident();
    bus.select_puf = 3'd2;
    bus.reset_puf = 1'b1;
    tick();
    bus.reset_puf = 1'b0;
    rep(3); rep(3); rep(3);
    bus.osc_count = 8'd7;
    bus.enable_puf = 1'b1;
    tick();
    bus.enable_puf = 1'b0;
    bus.store_response_puf = 1'b1;
    tick();
    bus.store_response_puf = 1'b0;
    load(3'd3, 3, 3, 3, 3);
    run_and_check("coincident", 2'b11);
  endtask

  task automatic test_tie();
    load(3'd0, 12, 12, 12, 12);
    load(3'd1, 12, 12, 12, 12);
    run_and_check("tie", 2'b10);
  endtask

  task automatic test_saturate();
    bus.select_puf = 3'd0;
    bus.reset_puf = 1'b1;
    tick();
    bus.reset_puf = 1'b0;
    for (int i = 0; i < 9; i++) rep(8'd255);
    bus.store_response_puf = 1'b1;
    tick();
    bus.store_response_puf = 1'b0;
    load(3'd1, 254, 254, 254, 254);
    load(3'd4, 0, 0, 0, 0);
    bus.done = 1'b1;
    tick(); tick(); tick();
    total++;
    if (bus.response !== 2'b11) begin
      bad++; $display("FAIL saturate got r=%b exp r=11", bus.response);
    end
    bus.resp_ready = 1'b1;
    bus.done = 1'b0;
    tick();
    bus.resp_ready = 1'b0;
    total++;
    if (bus.next_enable !== 1'b0 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL early_idle got ne=%b v=%b exp ne=0 v=0",
                      bus.next_enable, bus.resp_valid);
    end
    tick();
    total++;
    if (bus.next_enable !== 1'b1) begin
      bad++; $display("FAIL early_ret got ne=%b exp=1", bus.next_enable);
    end
  endtask

  task automatic test_overrun_reset();
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++; $display("FAIL ovr_pre got=%b exp=0", bus.overrun);
    end
    bus.osc_count = 8'd0;
    bus.done = 1'b1;
    tick();
    bus.enable_puf = 1'b1;
    tick();
    bus.enable_puf = 1'b0;
    tick();
    total++;
    if (bus.overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_set got=%b exp=1", bus.overrun);
    end
    total++;
    if (bus.resp_valid !== 1'b1 || bus.response !== 2'b11) begin
      bad++; $display("FAIL ovr_table got v=%b r=%b exp v=1 r=11",
                      bus.resp_valid, bus.response);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.next_enable !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.response !== 2'b00 || bus.overrun !== 1'b0) begin
      bad++; $display("FAIL async_rst got ne=%b v=%b r=%b o=%b exp 1 0 00 0",
                      bus.next_enable, bus.resp_valid,
                      bus.response, bus.overrun);
    end
    bus.done = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_retrigger();
    bus.done = 1'b1;
    tick(); tick(); tick();
    total++;
    if (bus.resp_valid !== 1'b1 || bus.response !== 2'b00) begin
      bad++; $display("FAIL cleared_tbl got v=%b r=%b exp v=1 r=00",
                      bus.resp_valid, bus.response);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (bus.next_enable !== 1'b0 || bus.resp_valid !== 1'b0) begin
        bad++; $display("FAIL retrig_%0d got ne=%b v=%b exp ne=0 v=0",
                        i, bus.next_enable, bus.resp_valid);
      end
    end
    bus.done = 1'b0;
    tick();
    tick(); tick();
    total++;
    if (bus.next_enable !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL retrig_end got ne=%b v=%b exp ne=1 v=0",
                      bus.next_enable, bus.resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_backpressure();
    test_coincident();
    test_tie();
    test_saturate();
    test_overrun_reset();
    test_no_retrigger();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
